// File: rtl/seq_alu_unit.sv
// seq_alu_unit: multi-cycle ALU (IDLE/EXEC/SHIFT/DONE) with registered result, flags and a bit-serial SLL
module seq_alu_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  AluControl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [4:0]  Shamt,
  output logic [31:0] AluResult,
  output logic        Zero,
  output logic        Overflow,
  output logic        Busy,
  output logic        Done,
  output logic        Error
);
  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;
  state_t      r_state, w_next;
  logic [31:0] r_a, r_b, r_work, r_result;
  logic [3:0]  r_op;
  logic [4:0]  r_sh, r_cnt;
  logic        r_err, r_zero, r_ovf;
  logic [31:0] w_sum, w_diff, w_res, w_shl;
  logic        w_ovf, w_ill;
  assign w_sum  = r_a + r_b;
  assign w_diff = r_a - r_b;
  assign w_shl  = r_work << 1;
  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    w_ill = 1'b0;
    case (r_op)
      4'd0:    w_res = r_a & r_b;
      4'd1:    w_res = r_a | r_b;
      4'd2:    begin
                 w_res = w_sum;
                 w_ovf = (r_a[31] == r_b[31]) && (w_sum[31] != r_a[31]);
               end
      4'd6:    begin
                 w_res = w_diff;
                 w_ovf = (r_a[31] != r_b[31]) && (w_diff[31] != r_a[31]);
               end
      4'd7:    w_res = {31'd0, $signed(r_a) < $signed(r_b)};
      4'd12:   w_res = ~(r_a | r_b);
      4'd13:   w_res = r_a;
      default: w_ill = 1'b1;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_sh     <= '0;
      r_work   <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_ovf    <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (Start) begin
          r_a  <= A;
          r_b  <= B;
          r_op <= AluControl;
          r_sh <= Shamt;
        end
        EXEC: begin
          r_work <= r_a;
          r_cnt  <= r_sh;
          r_err  <= w_ill;
          if (w_next == DONE) begin
            r_result <= w_res;
            r_zero   <= w_res == '0;
            r_ovf    <= w_ovf;
          end
        end
        SHIFT: begin
          r_work <= w_shl;
          r_cnt  <= r_cnt - 5'd1;
          if (w_next == DONE) begin
            r_result <= w_shl;
            r_zero   <= w_shl == '0;
            r_ovf    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = Start ? EXEC : IDLE;
      EXEC:    w_next = (r_op == 4'd13 && r_sh != 5'd0) ? SHIFT : DONE;
      SHIFT:   w_next = (r_cnt == 5'd1) ? DONE : SHIFT;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    Busy  = r_state != IDLE;
    Done  = r_state == DONE;
    Error = (r_state == DONE) && r_err;
  end
  assign AluResult = r_result;
  assign Zero      = r_zero;
  assign Overflow  = r_ovf;
endmodule

// File: doc/seq_alu_unit.md
SEQ_ALU_UNIT -- requirements
Module: seq_alu_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, using the ports clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 Start  input  1  request; sampled only in IDLE.
REQ-005 AluControl  input  4  operation code from the ALU control unit.
REQ-006 A  input  32  operand 1 (read register 1).
REQ-007 B  input  32  operand 2 (read register 2 or immediate).
REQ-008 Shamt  input  5  shift amount, used by SLL only.
REQ-009 AluResult  output  32  registered result; valid when Done=1, held until the next accepted Start.
REQ-010 Zero  output  1  registered, equals (AluResult==0); updated together with AluResult.
REQ-011 Overflow  output  1  registered signed overflow for ADD or SUB; 0 for all other codes.
REQ-012 Busy  output  1  high in every state except IDLE.
REQ-013 Done  output  1  one-cycle completion pulse.
REQ-014 Error  output  1  one-cycle pulse, coincident with Done, for an illegal AluControl code.

Function
REQ-015 States SHALL be IDLE, EXEC, SHIFT and DONE, held in a registered FSM.
REQ-016 IDLE with Start=1 SHALL capture A, B, AluControl and Shamt into internal registers and go to EXEC.
- The captured values alone determine the result.
- Input changes after capture SHALL have no effect.
REQ-017 IDLE with Start=0 SHALL remain in IDLE with all outputs held.
REQ-018 Start SHALL be ignored in EXEC, SHIFT and DONE; the request is neither queued nor counted.
REQ-019 EXEC SHALL compute the result from the captured code:
- 0 = A AND B
- 1 = A OR B
- 2 = A+B, mod 2^32
- 6 = A-B, mod 2^32
- 7 = 1 if signed A < signed B, else 0
- 12 = NOR(A,B)
- 13 = SLL
REQ-020 Overflow SHALL be set for code 2 when A[31]==B[31] and sum[31]!=A[31].
REQ-021 Overflow SHALL be set for code 6 when A[31]!=B[31] and diff[31]!=A[31].
REQ-022 SLT SHALL use the true signed comparison, not the sign of a wrapped difference.
REQ-023 SLL in EXEC SHALL load a working register with A and a counter with Shamt.
- Counter=0: go directly to DONE with result A.
- Counter≠0: go to SHIFT.
REQ-024 SHIFT SHALL shift the working register left by 1, filling with 0, and decrement the counter each cycle; the transition to DONE SHALL occur when the counter reaches 0.
REQ-025 Any other code (3,4,5,8–11,14,15) SHALL give AluResult=0, Zero=1, Overflow=0, and assert Error in the DONE cycle.
REQ-026 AluResult, Zero and Overflow SHALL be written on the EXEC→DONE or SHIFT→DONE transition only.
REQ-027 Done SHALL be 1 only while in DONE; DONE SHALL always return to IDLE after one cycle.
REQ-028 Latency: Start accepted on edge T gives Done=1 in the cycle following edge T+2 for non-shift codes, and in the cycle following edge T+2+Shamt for SLL.
REQ-029 Back-to-back: Start asserted continuously SHALL be accepted in every IDLE cycle, so a new operation begins every 3 cycles for non-shift codes.

Reset
REQ-030 reset=1 at a clock edge SHALL force IDLE and clear all internal registers to 0.
REQ-031 reset=1 at a clock edge SHALL set AluResult=0, Zero=1, Overflow=0, Busy=0, Done=0 and Error=0.
REQ-032 reset SHALL take priority over Start at the same edge.
REQ-033 reset during EXEC or SHIFT SHALL abort the operation with no Done pulse; the partial result SHALL be discarded.
REQ-034 The first Start after reset is released SHALL be accepted normally.

Verification
REQ-035 ADD overflow: A=0x7FFFFFFF, B=1, code 2 -> AluResult=0x80000000, Overflow=1, Zero=0, Done 2 cycles after acceptance.
REQ-036 SUB and SLT: A=5, B=5, code 6 -> AluResult=0, Zero=1; then A=0xFFFFFFFF, B=1, code 7 -> AluResult=1.
REQ-037 SLL: A=0x00000003, Shamt=4, code 13 -> AluResult=0x30, Busy high for 6 cycles, Done at T+6.
- Repeat with Shamt=0 -> AluResult=3, Done at T+2.
- Repeat with Shamt=31, A=1 -> AluResult=0x80000000.
REQ-038 Illegal and NOR: code 9 -> Error=1 with Done, AluResult=0; then code 12, A=0, B=0 -> AluResult=0xFFFFFFFF, Error=0.
REQ-039 Busy rejection: Start held high, A changed to 7 during EXEC of an ADD of 1+1 -> AluResult=2, exactly one Done, next operation accepted in the following IDLE cycle.
REQ-040 Reset mid-shift: SLL with Shamt=20, reset asserted in the 5th SHIFT cycle -> no Done, all outputs at reset values next cycle, a following OR 0xF0|0x0F returns 0xFF.
